// File: rtl/avr_irq_pkg.sv
// avr_irq_pkg: shared types and constants for the AVR interrupt arbiter.
//   irq_state_t  : arbiter FSM states
//   VEC_W        : vector index width
//   USART0_*     : ATmega328PB vector indices for the USART0 sources
package avr_irq_pkg;

  localparam int unsigned VEC_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    GUARD
  } irq_state_t;

  localparam logic [VEC_W-1:0] USART0_RX    = 6'h12;
  localparam logic [VEC_W-1:0] USART0_UDRE  = 6'h13;
  localparam logic [VEC_W-1:0] USART0_TX    = 6'h14;
  localparam logic [VEC_W-1:0] USART0_START = 6'h1A;

endpackage

// File: rtl/avr_irq_prio_enc.sv
// avr_irq_prio_enc: combinational lowest-index priority encoder.
//   i_req [NUM_IRQ] : request vector, bit k = index k
//   o_sel [VEC_W]   : lowest set index (0 when none set)
//   o_any           : at least one request bit set
module avr_irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 64,
  parameter int unsigned VEC_W   = 6
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [VEC_W-1:0]   o_sel,
  output logic               o_any
);

  always_comb begin
    o_sel = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (i_req[i] && !o_any) begin
        o_sel = VEC_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avr_irq_arbiter.sv
// avr_irq_arbiter: fixed-priority interrupt arbiter (lowest vector wins).
//   cp2          : system clock, rising edge
//   ireset       : synchronous active-high reset
//   irq_lines    : level requests, bit k = vector k (bit 0 ignored)
//   global_ie    : SREG.I
//   core_ready   : core at an instruction boundary
//   irq_take     : core accepts the presented vector
//   irq_req      : request to core
//   irq_vec      : vector presented with irq_req (held while idle)
//   irqack       : one-cycle acknowledge to peripherals
//   irqack_addr  : vector being acknowledged (held between pulses)
//   irq_busy     : arbiter not idle
module avr_irq_arbiter #(
  parameter int unsigned NUM_IRQ   = 64,
  parameter int unsigned VEC_W     = avr_irq_pkg::VEC_W,
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic               cp2,
  input  logic               ireset,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               global_ie,
  input  logic               core_ready,
  input  logic               irq_take,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  output logic               irqack,
  output logic [VEC_W-1:0]   irqack_addr,
  output logic               irq_busy
);

  import avr_irq_pkg::*;

  localparam int unsigned GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

  irq_state_t         r_state;
  irq_state_t         w_state_nx;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   r_ack_addr;
  logic [GW-1:0]      r_guard;
  logic [NUM_IRQ-1:0] w_pending;
  logic [VEC_W-1:0]   w_sel;
  logic               w_any;

  // Vector 0 is reset and never arbitrated.
  assign w_pending = irq_lines & ~(NUM_IRQ'(1));

  avr_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .i_req (w_pending),
    .o_sel (w_sel),
    .o_any (w_any)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (global_ie && core_ready && w_any) w_state_nx = REQ;
      end
      REQ: begin
        // take has priority over a cancel in the same cycle
        if (irq_take)                             w_state_nx = ACK;
        else if (!global_ie || !irq_lines[r_vec]) w_state_nx = IDLE;
      end
      ACK: begin
        w_state_nx = (GUARD_CYC == 0) ? IDLE : GUARD;
      end
      GUARD: begin
        // counter is loaded with GUARD_CYC on ACK; leave when it would hit 0
        if (r_guard <= GW'(1)) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_ack_addr <= '0;
      r_guard    <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && w_state_nx == REQ) r_vec <= w_sel;
      if (r_state == REQ && w_state_nx == ACK)  r_ack_addr <= r_vec;
      if (r_state == ACK)
        r_guard <= GW'(GUARD_CYC);
      else if (r_state == GUARD && r_guard != '0)
        r_guard <= r_guard - GW'(1);
    end
  end

  assign irq_req     = (r_state == REQ);
  assign irq_vec     = r_vec;
  assign irqack      = (r_state == ACK);
  assign irqack_addr = r_ack_addr;
  assign irq_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_avr_irq_arbiter.sv
module tb_avr_irq_arbiter;

  localparam int unsigned NUM_IRQ   = 64;
  localparam int unsigned VEC_W     = 6;
  localparam int unsigned GUARD_CYC = 2;

  localparam logic [63:0] B0  = 64'd1;
  localparam logic [63:0] B18 = 64'd1 << 18;
  localparam logic [63:0] B19 = 64'd1 << 19;
  localparam logic [63:0] B20 = 64'd1 << 20;
  localparam logic [63:0] B21 = 64'd1 << 21;

  logic        cp2 = 1'b0;
  logic        ireset;
  logic [63:0] irq_lines;
  logic        global_ie, core_ready, irq_take;
  logic        irq_req, irqack, irq_busy;
  logic [5:0]  irq_vec, irqack_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 cp2 = ~cp2;

  avr_irq_arbiter #(
    .NUM_IRQ   (NUM_IRQ),
    .VEC_W     (VEC_W),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .cp2         (cp2),
    .ireset      (ireset),
    .irq_lines   (irq_lines),
    .global_ie   (global_ie),
    .core_ready  (core_ready),
    .irq_take    (irq_take),
    .irq_req     (irq_req),
    .irq_vec     (irq_vec),
    .irqack      (irqack),
    .irqack_addr (irqack_addr),
    .irq_busy    (irq_busy)
  );

  typedef struct {
    logic        rst;
    logic [63:0] lines;
    logic        ie, rdy, take;
    logic        ereq;
    logic [5:0]  evec;
    logic        eack;
    logic [5:0]  eaddr;
    logic        ebusy;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(logic rst, logic [63:0] lines, logic ie, logic rdy, logic take,
                              logic ereq, logic [5:0] evec, logic eack, logic [5:0] eaddr,
                              logic ebusy);
    row_t r;
    r.rst = rst; r.lines = lines; r.ie = ie; r.rdy = rdy; r.take = take;
    r.ereq = ereq; r.evec = evec; r.eack = eack; r.eaddr = eaddr; r.ebusy = ebusy;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [63:0] lines, input logic ie,
                       input logic rdy, input logic take);
    ireset = rst; irq_lines = lines; global_ie = ie; core_ready = rdy; irq_take = take;
  endtask

  task automatic check(input string name, input logic req, input logic [5:0] vec,
                       input logic ack, input logic [5:0] addr, input logic busy);
    n_tests++;
    if ({irq_req, irq_vec, irqack, irqack_addr, irq_busy} !== {req, vec, ack, addr, busy}) begin
      n_fail++;
      $display("FAIL %s: got req=%0b vec=%h ack=%0b addr=%h busy=%0b, expected req=%0b vec=%h ack=%0b addr=%h busy=%0b",
               name, irq_req, irq_vec, irqack, irqack_addr, irq_busy, req, vec, ack, addr, busy);
    end
  endtask

  function automatic logic [5:0] lowest(input logic [63:0] lines);
    for (int i = 1; i < 64; i++)
      if (lines[i]) return 6'(i);
    return 6'd0;
  endfunction

  initial begin
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);

    // rst lines ie rdy take | req vec ack addr busy
    tbl.push_back(mk(1, 0,          0, 0, 0,  0, 6'h00, 0, 6'h00, 0)); // 0 reset
    tbl.push_back(mk(0, B20,        1, 1, 0,  1, 6'h14, 0, 6'h00, 1)); // 1 TXC request
    tbl.push_back(mk(0, B20,        1, 1, 1,  0, 6'h14, 1, 6'h14, 1)); // 2 ack
    tbl.push_back(mk(0, B20,        1, 1, 0,  0, 6'h14, 0, 6'h14, 1)); // 3 guard
    tbl.push_back(mk(0, B20,        1, 1, 0,  0, 6'h14, 0, 6'h14, 1)); // 4 guard
    tbl.push_back(mk(0, B20,        1, 1, 0,  0, 6'h14, 0, 6'h14, 0)); // 5 idle
    tbl.push_back(mk(0, B20,        1, 1, 0,  1, 6'h14, 0, 6'h14, 1)); // 6 re-request
    tbl.push_back(mk(0, 0,          1, 1, 0,  0, 6'h14, 0, 6'h14, 0)); // 7 line drop cancel
    tbl.push_back(mk(0, B19,        0, 1, 0,  0, 6'h14, 0, 6'h14, 0)); // 8 ie=0 blocks
    tbl.push_back(mk(0, B19,        1, 1, 0,  1, 6'h13, 0, 6'h14, 1)); // 9 ie raised
    tbl.push_back(mk(0, B19,        0, 1, 0,  0, 6'h13, 0, 6'h14, 0)); // 10 ie drop cancel
    tbl.push_back(mk(0, B20,        1, 1, 0,  1, 6'h14, 0, 6'h14, 1)); // 11 request 0x14
    tbl.push_back(mk(0, B20|B18,    1, 1, 0,  1, 6'h14, 0, 6'h14, 1)); // 12 no preempt
    tbl.push_back(mk(0, B18,        1, 1, 1,  0, 6'h14, 1, 6'h14, 1)); // 13 take beats drop
    tbl.push_back(mk(0, B18,        1, 1, 0,  0, 6'h14, 0, 6'h14, 1)); // 14 guard
    tbl.push_back(mk(0, B18,        1, 1, 0,  0, 6'h14, 0, 6'h14, 1)); // 15 guard
    tbl.push_back(mk(0, B18,        1, 1, 0,  0, 6'h14, 0, 6'h14, 0)); // 16 idle
    tbl.push_back(mk(0, B18,        1, 1, 0,  1, 6'h12, 0, 6'h14, 1)); // 17 0x12 presented
    tbl.push_back(mk(1, B18,        1, 1, 0,  0, 6'h00, 0, 6'h00, 0)); // 18 reset mid REQ
    tbl.push_back(mk(0, B0,         1, 1, 0,  0, 6'h00, 0, 6'h00, 0)); // 19 bit0 ignored
    tbl.push_back(mk(0, B0,         1, 1, 0,  0, 6'h00, 0, 6'h00, 0)); // 20 bit0 ignored
    tbl.push_back(mk(0, B18|B19|B20,1, 1, 0,  1, 6'h12, 0, 6'h00, 1)); // 21 lowest wins
    tbl.push_back(mk(0, B18|B19|B20,1, 1, 1,  0, 6'h12, 1, 6'h12, 1)); // 22 ack 0x12
    tbl.push_back(mk(0, B19|B20,    1, 1, 0,  0, 6'h12, 0, 6'h12, 1)); // 23 guard
    tbl.push_back(mk(0, B19|B20,    1, 1, 0,  0, 6'h12, 0, 6'h12, 1)); // 24 guard
    tbl.push_back(mk(0, B19|B20,    1, 1, 0,  0, 6'h12, 0, 6'h12, 0)); // 25 idle
    tbl.push_back(mk(0, B19|B20,    1, 1, 0,  1, 6'h13, 0, 6'h12, 1)); // 26 0x13
    tbl.push_back(mk(0, B19|B20,    1, 1, 1,  0, 6'h13, 1, 6'h13, 1)); // 27 ack 0x13
    tbl.push_back(mk(0, B20,        1, 1, 0,  0, 6'h13, 0, 6'h13, 1)); // 28 guard
    tbl.push_back(mk(0, B20,        1, 1, 0,  0, 6'h13, 0, 6'h13, 1)); // 29 guard
    tbl.push_back(mk(0, B20,        1, 1, 0,  0, 6'h13, 0, 6'h13, 0)); // 30 idle
    tbl.push_back(mk(0, B20,        1, 1, 0,  1, 6'h14, 0, 6'h13, 1)); // 31 0x14
    tbl.push_back(mk(0, B20,        1, 1, 1,  0, 6'h14, 1, 6'h14, 1)); // 32 ack 0x14
    tbl.push_back(mk(0, 0,          1, 1, 0,  0, 6'h14, 0, 6'h14, 1)); // 33 guard
    tbl.push_back(mk(0, 0,          1, 1, 0,  0, 6'h14, 0, 6'h14, 1)); // 34 guard
    tbl.push_back(mk(0, 0,          1, 1, 0,  0, 6'h14, 0, 6'h14, 0)); // 35 idle
    tbl.push_back(mk(0, B21,        1, 0, 0,  0, 6'h14, 0, 6'h14, 0)); // 36 core not ready
    tbl.push_back(mk(0, B21,        1, 1, 0,  1, 6'h15, 0, 6'h14, 1)); // 37 ready -> req
    tbl.push_back(mk(0, B21,        0, 1, 1,  0, 6'h15, 1, 6'h15, 1)); // 38 take beats ie drop
    tbl.push_back(mk(0, 0,          1, 1, 1,  0, 6'h15, 0, 6'h15, 1)); // 39 take ignored in guard
    tbl.push_back(mk(0, 0,          1, 1, 1,  0, 6'h15, 0, 6'h15, 1)); // 40 guard
    tbl.push_back(mk(0, 0,          1, 1, 1,  0, 6'h15, 0, 6'h15, 0)); // 41 idle
    tbl.push_back(mk(0, 0,          1, 1, 1,  0, 6'h15, 0, 6'h15, 0)); // 42 take ignored in idle

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].lines, tbl[i].ie, tbl[i].rdy, tbl[i].take);
      @(posedge cp2); #1;
      check($sformatf("row%0d", i), tbl[i].ereq, tbl[i].evec, tbl[i].eack,
            tbl[i].eaddr, tbl[i].ebusy);
    end

    // Randomised phase against a timestamp-based reference model.
    begin
      int          cand[8] = '{0, 1, 5, 18, 19, 20, 40, 63};
      logic [63:0] lines = '0;
      logic        rst, ie, rdy, take;
      logic        m_req = 1'b0, m_ack = 1'b0;
      logic [5:0]  m_vec = '0, m_addr = '0, sel;
      logic        m_busy;
      longint      t = 0;
      longint      last_ack = -100;
      longint      G = longint'(GUARD_CYC);

      for (int c = 0; c < 3000; c++) begin
        for (int k = 0; k < 8; k++)
          if ($urandom_range(0, 15) == 0) lines[cand[k]] = ~lines[cand[k]];
        rst  = (c == 0) || ($urandom_range(0, 199) == 0);
        ie   = ($urandom_range(0, 9) != 0);
        rdy  = ($urandom_range(0, 3) != 0);
        take = ($urandom_range(0, 2) == 0);
        drive(rst, lines, ie, rdy, take);

        t++;
        if (rst) begin
          m_req = 1'b0; m_ack = 1'b0; m_vec = '0; m_addr = '0; last_ack = -100;
        end else if (m_req) begin
          m_ack = take;
          if (take) begin
            m_addr = m_vec; last_ack = t; m_req = 1'b0;
          end else if (!ie || !lines[m_vec]) begin
            m_req = 1'b0;
          end
        end else begin
          m_ack = 1'b0;
          sel = lowest(lines);
          // the previous cycle must have been idle: not within ack+guard window
          if ((t - 1 > last_ack + G) && ie && rdy && sel != 6'd0) begin
            m_req = 1'b1; m_vec = sel;
          end
        end
        m_busy = m_req || m_ack || (t > last_ack && t <= last_ack + G);

        @(posedge cp2); #1;
        check($sformatf("rand%0d", c), m_req, m_vec, m_ack, m_addr, m_busy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
